// File: rtl/axis_upsizer_pkg.sv
// Shared helpers for the AXI-Stream upsizer: lane-index sizing and byte-lane keep masks.
package axis_upsizer_pkg;

  // Upper bound on master byte lanes; callers truncate with a size cast.
  localparam int KEEP_MAX = 1024;

  function automatic int lane_idx_width(input int ratio);
    return ($clog2(ratio) > 1) ? $clog2(ratio) : 1;
  endfunction

  function automatic logic [KEEP_MAX-1:0] keep_mask(input int idx, input int ratio,
                                                   input int sdw);
    logic [KEEP_MAX-1:0] m;
    m = '0;
    for (int b = 0; b < KEEP_MAX; b++) begin
      if ((b < (idx + 1) * (sdw / 8)) && (b < ratio * (sdw / 8))) m[b] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/axis_upsizer_outreg.sv
// Single-entry valid/ready output register carrying an opaque payload.
// Handshake: upstream may load only while accept=1 (accept = !valid | ready); a word
// transfers downstream when valid & ready; a load in the draining cycle replaces it.
module axis_upsizer_outreg #(
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [PW-1:0] load_payload,
  input  logic          ready,
  output logic          valid,
  output logic [PW-1:0] payload,
  output logic          accept
);

  assign accept = !valid || ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid   <= 1'b0;
      payload <= '0;
    end else if (load) begin
      valid   <= 1'b1;
      payload <= load_payload;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/axis_upsizer.sv
// AXI-Stream width upsizer: packs RATIO slave beats into one master beat, lane 0 in LSBs.
// Optional byte-lane M_AXIS_TKEEP is enabled by defining AXIS_UPSIZER_TKEEP_EN.
module axis_upsizer
  import axis_upsizer_pkg::*;
#(
  parameter int S_DATA_WIDTH = 32,
  parameter int RATIO        = 2,
  parameter int USER_WIDTH   = 32
) (
  input  logic                          AXIS_ACLK,
  input  logic                          AXIS_ARESET,
  input  logic [S_DATA_WIDTH-1:0]       S_AXIS_TDATA,
  input  logic                          S_AXIS_TVALID,
  input  logic                          S_AXIS_TLAST,
  output logic                          S_AXIS_TREADY,
  output logic [RATIO*S_DATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic                          M_AXIS_TVALID,
  output logic                          M_AXIS_TLAST,
  output logic [USER_WIDTH-1:0]         M_AXIS_TUSER,
`ifdef AXIS_UPSIZER_TKEEP_EN
  output logic [RATIO*S_DATA_WIDTH/8-1:0] M_AXIS_TKEEP,
`endif
  input  logic                          M_AXIS_TREADY,
  input  logic [USER_WIDTH-1:0]         SRCDEST
);

  localparam int SW = S_DATA_WIDTH;
  localparam int MW = RATIO * SW;
  localparam int IW = lane_idx_width(RATIO);
`ifdef AXIS_UPSIZER_TKEEP_EN
  localparam int KW = MW / 8;
  localparam int PW = KW + USER_WIDTH + 1 + MW;
`else
  localparam int PW = USER_WIDTH + 1 + MW;
`endif

  logic [IW-1:0]         idx;
  logic                  sop;
  logic [MW-1:0]         acc;
  logic [USER_WIDTH-1:0] pend_user;
  logic                  s_xfr;
  logic                  complete;
  logic [MW-1:0]         word;
  logic [USER_WIDTH-1:0] user_now;
  logic [PW-1:0]         payload_in;
  logic [PW-1:0]         payload;

  assign s_xfr    = S_AXIS_TVALID && S_AXIS_TREADY;
  assign complete = s_xfr && ((idx == IW'(RATIO - 1)) || S_AXIS_TLAST);
  // A packet's first beat may also complete it, so bypass the pending register then.
  assign user_now = sop ? SRCDEST : pend_user;

  always_comb begin
    word = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (IW'(i) < idx) word[i*SW +: SW] = acc[i*SW +: SW];
      else if (IW'(i) == idx) word[i*SW +: SW] = S_AXIS_TDATA;
    end
  end

`ifdef AXIS_UPSIZER_TKEEP_EN
  logic [KW-1:0] keep;
  assign keep       = KW'(keep_mask(int'(idx), RATIO, SW));
  assign payload_in = {keep, user_now, S_AXIS_TLAST, word};
  assign {M_AXIS_TKEEP, M_AXIS_TUSER, M_AXIS_TLAST, M_AXIS_TDATA} = payload;
`else
  assign payload_in = {user_now, S_AXIS_TLAST, word};
  assign {M_AXIS_TUSER, M_AXIS_TLAST, M_AXIS_TDATA} = payload;
`endif

  always_ff @(posedge AXIS_ACLK) begin
    if (AXIS_ARESET) begin
      idx       <= '0;
      sop       <= 1'b1;
      acc       <= '0;
      pend_user <= '0;
    end else if (s_xfr) begin
      if (sop) pend_user <= SRCDEST;
      sop <= S_AXIS_TLAST;
      if (complete) begin
        acc <= '0;
        idx <= '0;
      end else begin
        for (int i = 0; i < RATIO - 1; i++) begin
          if (idx == IW'(i)) acc[i*SW +: SW] <= S_AXIS_TDATA;
        end
        idx <= idx + 1'b1;
      end
    end
  end

  axis_upsizer_outreg #(
    .PW(PW)
  ) u_outreg (
    .clk         (AXIS_ACLK),
    .rst         (AXIS_ARESET),
    .load        (complete),
    .load_payload(payload_in),
    .ready       (M_AXIS_TREADY),
    .valid       (M_AXIS_TVALID),
    .payload     (payload),
    .accept      (S_AXIS_TREADY)
  );

endmodule

// File: doc/axis_upsizer.md
# axis_upsizer

Parametrised AXI-Stream width upsizer: packs RATIO consecutive S_DATA_WIDTH-bit slave beats into one RATIO×S_DATA_WIDTH-bit master beat, lane 0 in the LSBs. It sits between 32-bit VITA-49 packet sources and wide unpack/DMA datapaths. It generalises the fixed 32→64 packer to any ratio. It also adds a registered output stage with full-throughput backpressure, TLAST on partial words, optional byte-lane TKEEP, and per-packet TUSER capture of SRCDEST.

## Interface
- S_DATA_WIDTH, 32: slave data width in bits; multiple of 8.
- RATIO, 2: slave beats per master beat; ≥2.
- USER_WIDTH, 32: width of SRCDEST / M_AXIS_TUSER.
- AXIS_ACLK  in  1  the only clock; all logic on the rising edge.
- AXIS_ARESET  in  1  synchronous, active-high reset.
- S_AXIS_TDATA  in  S_DATA_WIDTH  slave data.
- S_AXIS_TVALID  in  1  slave valid.
- S_AXIS_TLAST  in  1  slave end of packet.
- S_AXIS_TREADY  out  1  slave ready.
- M_AXIS_TDATA  out  RATIO*S_DATA_WIDTH  packed data.
- M_AXIS_TVALID  out  1  master valid.
- M_AXIS_TLAST  out  1  master end of packet.
- M_AXIS_TUSER  out  USER_WIDTH  SRCDEST captured at the packet's first beat.
- M_AXIS_TKEEP  out  RATIO*S_DATA_WIDTH/8  byte enables. Present only with AXIS_UPSIZER_TKEEP_EN.
- M_AXIS_TREADY  in  1  master ready.
- SRCDEST  in  USER_WIDTH  routing tag, sampled per packet.

## Operation
- s_xfr = S_AXIS_TVALID & S_AXIS_TREADY; m_xfr = M_AXIS_TVALID & M_AXIS_TREADY.
- State: lane index idx (0..RATIO-1), first-of-packet flag sop (reset 1), accumulator holding lanes 0..RATIO-2, output register (data, last, user, keep, valid).
- On s_xfr with idx < RATIO-1 and !S_AXIS_TLAST:
  - write lane idx of the accumulator;
  - idx++.
- On s_xfr with idx == RATIO-1 or S_AXIS_TLAST ("completing beat"):
  - output data = accumulator lanes 0..idx-1, plus the incoming beat in lane idx;
  - lanes above idx are forced to 0;
  - M_AXIS_TLAST = S_AXIS_TLAST;
  - the output register is loaded and valid set;
  - the accumulator is cleared and idx returns to 0.
- TUSER capture:
  - on s_xfr with sop=1, SRCDEST is latched into a pending-user register;
  - each output word carries the pending-user value;
  - sop is set by TLAST acceptance and cleared by any other s_xfr.
- A packet of K beats yields ceil(K/RATIO) master beats. Only the final one can be partial.
- S_AXIS_TREADY = !M_AXIS_TVALID | M_AXIS_TREADY.
  - This holds in all idx states, including non-completing beats.
  - It gives full throughput: one master beat per RATIO slave beats with no bubbles.
- Output valid is cleared on m_xfr unless a completing beat loads the register in the same cycle (simultaneous load and drain: the new word wins, valid stays 1).
- While M_AXIS_TVALID=1 and M_AXIS_TREADY=0, all master outputs hold stable.

## Timing
- Reset values:
  - outputs: M_AXIS_TVALID=0, M_AXIS_TDATA=0, M_AXIS_TLAST=0, M_AXIS_TUSER=0, M_AXIS_TKEEP=0;
  - S_AXIS_TREADY=1 (combinational from output valid);
  - internal: idx=0, sop=1, accumulator=0.
- Latency: a master word is valid on the cycle after its completing slave beat.
- Reset mid-packet discards the accumulated lanes and any pending output word. The first beat after reset is treated as start of packet.
- A single-beat packet (TLAST at idx=0) emits one word with lane 0 only.
- TLAST exactly at idx=RATIO-1 emits a full word with TLAST=1.

## Configuration
- AXIS_UPSIZER_TKEEP_EN defined:
  - M_AXIS_TKEEP exists;
  - each of lanes 0..idx contributes S_DATA_WIDTH/8 ones; higher bytes are 0.
- Undefined:
  - no TKEEP port;
  - partial words are zero-padded only;
  - downstream derives length from packet headers.

## Structure
- Package axis_upsizer_pkg holds:
  - function lane_idx_width(RATIO) returning max(1, $clog2(RATIO));
  - function keep_mask(idx, RATIO, S_DATA_WIDTH).
- One natural sub-module: axis_upsizer_outreg. It is the single output register with valid/ready, simultaneous load/drain and the TREADY equation, and it is reusable by sibling downsizers.

## Test plan
- RATIO=2, SRCDEST=0xA5A5_0001; slave beats 0x11111111, 0x22222222 with TLAST on the second:
  - one master beat 0x22222222_11111111, TLAST=1, TUSER=0xA5A50001, TKEEP=0xFF.
- RATIO=4, 5-beat packet 1..5 with TLAST on beat 5:
  - beat A = 0x00000004_00000003_00000002_00000001, TLAST=0, TKEEP=0xFFFF;
  - beat B = 0x...00000005 with upper lanes zero, TLAST=1, TKEEP=0x000F.
- RATIO=2, continuous slave valid, M_AXIS_TREADY tied 1, 64 beats:
  - S_AXIS_TREADY is never low;
  - exactly 32 master beats.
- RATIO=2, M_AXIS_TREADY held 0 for 10 cycles after the first master word:
  - S_AXIS_TREADY=0 once the output is full and a completing beat is pending;
  - the held word is stable;
  - no data is lost or duplicated after release.
- Back-to-back packets with SRCDEST changing 0x1→0x2 mid-packet 1:
  - all of packet 1 carries TUSER=0x1;
  - packet 2 carries TUSER=0x2.
- AXIS_ARESET asserted after 3 of 4 lanes (RATIO=4), then a fresh 4-beat packet:
  - no word is emitted for the aborted lanes;
  - the next word contains only the fresh beats, TUSER from the new SRCDEST.
